// File: rtl/bfloat19_pkg.sv
// Shared bfloat19 definitions: 1 sign, 8 exponent (bias 127), 10 mantissa bits.
package bfloat19_pkg;

  localparam int unsigned EXP_BITS = 8;
  localparam int unsigned MAN_BITS = 10;
  localparam int unsigned BF_WIDTH = 1 + EXP_BITS + MAN_BITS;
  localparam int unsigned BIAS     = 127;

  localparam logic [BF_WIDTH-1:0] ONE  = 19'h1FC00;
  localparam logic [BF_WIDTH-1:0] ZERO = 19'h00000;

  typedef struct packed {
    logic                sign;
    logic [EXP_BITS-1:0] exp;
    logic [MAN_BITS-1:0] man;
  } bf19_t;

  typedef enum logic [1:0] {
    ClsZero,
    ClsNorm,
    ClsOvf
  } bf19_cls_e;

  // Subnormals flush to zero; an all-ones exponent is treated as overflow.
  function automatic bf19_cls_e bf19_class(input bf19_t v);
    if (v.exp == '1) begin
      return ClsOvf;
    end else if (v.exp == '0) begin
      return ClsZero;
    end
    return ClsNorm;
  endfunction

endpackage

// File: rtl/fix2bf19_conv.sv
// Signed fixed-point to bfloat19 converter, two register stages (magnitude, normalize).
// MAC_ROUND_NEAREST_EN selects round-half-to-even; otherwise the mantissa truncates toward zero.
module fix2bf19_conv
  import bfloat19_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  input  logic                        valid_i,
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic                        ovf_i,
  output logic                        valid_o,
  output logic [BF_WIDTH-1:0]         num_o,
  output logic                        ovf_o
);

`ifdef MAC_ROUND_NEAREST_EN
  localparam int unsigned ExtBits = MAN_BITS + 2;
`else
  localparam int unsigned ExtBits = MAN_BITS;
`endif
  localparam int unsigned NormW = ACC_WIDTH - 1 + ExtBits;

  logic                   a_valid_q, a_sign_q, a_ovf_q;
  logic [ACC_WIDTH-2:0]   a_mag_q;
  logic [ACC_WIDTH-1:0]   neg_w;
  logic [ACC_WIDTH-2:0]   mag_w;

  logic [7:0]             k_w;
  logic [NormW-1:0]       norm_w;
  logic [EXP_BITS-1:0]    exp_w;
  logic [MAN_BITS-1:0]    man_w;
  logic [BF_WIDTH-1:0]    res_w;

  logic                   valid_q, ovf_q;
  logic [BF_WIDTH-1:0]    num_q;

  // Accumulator is clamped to +/-max, so the magnitude always fits ACC_WIDTH-1 bits.
  always_comb begin
    neg_w = '0 - acc_i;
    mag_w = acc_i[ACC_WIDTH-1] ? neg_w[ACC_WIDTH-2:0] : acc_i[ACC_WIDTH-2:0];
  end

  always_comb begin
    k_w = '0;
    for (int i = 0; i < int'(ACC_WIDTH) - 1; i++) begin
      if (a_mag_q[i]) begin
        k_w = 8'(i);
      end
    end
    norm_w = {a_mag_q, {ExtBits{1'b0}}} << (8'(ACC_WIDTH - 2) - k_w);
    exp_w  = k_w + 8'(BIAS) - 8'(FRAC_BITS);
    man_w  = norm_w[NormW-2 -: MAN_BITS];
    res_w  = {a_sign_q, exp_w, man_w};
`ifdef MAC_ROUND_NEAREST_EN
    // Mantissa carry ripples into the exponent through the packed add.
    if (norm_w[NormW-2-MAN_BITS] && ((|norm_w[NormW-3-MAN_BITS:0]) || man_w[0])) begin
      res_w = {a_sign_q, exp_w, man_w} + 19'd1;
    end
`endif
    if (!norm_w[NormW-1]) begin
      res_w = ZERO;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_valid_q <= 1'b0;
      a_sign_q  <= 1'b0;
      a_ovf_q   <= 1'b0;
      a_mag_q   <= '0;
      valid_q   <= 1'b0;
      num_q     <= ZERO;
      ovf_q     <= 1'b0;
    end else if (enable_i) begin
      a_valid_q <= valid_i;
      if (valid_i) begin
        a_sign_q <= acc_i[ACC_WIDTH-1];
        a_mag_q  <= mag_w;
        a_ovf_q  <= ovf_i;
      end
      valid_q <= a_valid_q;
      if (a_valid_q) begin
        num_q <= res_w;
        ovf_q <= a_ovf_q;
      end
    end
  end

  assign valid_o = valid_q;
  assign num_o   = num_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/neuron_mac_bfloat19.sv
// Streaming bfloat19 dot-product MAC: decode/multiply, align, saturating accumulate, convert.
// Output rounding is selected inside fix2bf19_conv by MAC_ROUND_NEAREST_EN.
module neuron_mac_bfloat19
  import bfloat19_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [BF_WIDTH-1:0] num_x,
  input  logic [BF_WIDTH-1:0] num_w,
  output logic                out_valid,
  output logic [BF_WIDTH-1:0] num_salida,
  output logic                ovf
);

  localparam int unsigned ProdW = 2 * (MAN_BITS + 1);
  localparam int unsigned WideW = ACC_WIDTH - 1 + ProdW;
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = -AccMax;
  localparam logic signed [ACC_WIDTH:0]   SumMax = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0]   SumMin = -SumMax;

  // S1: decode and multiply
  bf19_t              x_w, w_w;
  bf19_cls_e          cls_x_w, cls_w_w;
  logic               s1_ovf_d, s1_zero_d, s1_sign_d;
  logic signed [11:0] s1_exp_d;
  logic [ProdW-1:0]   s1_man_d;

  logic               s1_valid_q, s1_last_q, s1_ovf_q, s1_zero_q, s1_sign_q;
  logic signed [11:0] s1_exp_q;
  logic [ProdW-1:0]   s1_man_q;

  assign x_w = num_x;
  assign w_w = num_w;

  always_comb begin
    cls_x_w   = bf19_class(x_w);
    cls_w_w   = bf19_class(w_w);
    s1_ovf_d  = (cls_x_w == ClsOvf) || (cls_w_w == ClsOvf);
    s1_zero_d = !s1_ovf_d && ((cls_x_w == ClsZero) || (cls_w_w == ClsZero));
    s1_sign_d = x_w.sign ^ w_w.sign;
    s1_exp_d  = $signed({4'b0000, x_w.exp}) + $signed({4'b0000, w_w.exp}) - 12'sd254;
    s1_man_d  = ProdW'({1'b1, x_w.man}) * ProdW'({1'b1, w_w.man});
  end

  // S2: align into accumulator units, clamp and apply sign
  int                          sh_w;
  logic [WideW-1:0]            wide_w;
  logic                        big_w;
  logic [ACC_WIDTH-2:0]        mag_w;
  logic signed [ACC_WIDTH-1:0] p_w;

  logic                        s2_valid_q, s2_last_q, s2_ovf_q;
  logic signed [ACC_WIDTH-1:0] s2_p_q;

  always_comb begin
    wide_w = '0;
    big_w  = s1_ovf_q;
    sh_w   = int'(s1_exp_q) + int'(FRAC_BITS) - 20;
    if (!s1_ovf_q && !s1_zero_q) begin
      if (sh_w >= 0) begin
        // Leading product bit is at least bit 20, so larger shifts always overflow.
        if (sh_w > int'(ACC_WIDTH) - 1) begin
          big_w = 1'b1;
        end else begin
          wide_w = WideW'(s1_man_q) << sh_w;
          big_w  = |wide_w[WideW-1:ACC_WIDTH-1];
        end
      end else begin
        wide_w = WideW'(s1_man_q) >> (-sh_w);
      end
    end
    mag_w = big_w ? '1 : wide_w[ACC_WIDTH-2:0];
    p_w   = s1_sign_q ? ('0 - {1'b0, mag_w}) : {1'b0, mag_w};
  end

  // S3: saturating accumulate with sticky overflow
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_term_w;
  logic signed [ACC_WIDTH:0]   sum_w;
  logic                        first_q, sticky_q, sticky_d, add_ovf_w;
  logic                        s3_valid_q;

  always_comb begin
    acc_term_w = first_q ? '0 : acc_q;
    sum_w      = {acc_term_w[ACC_WIDTH-1], acc_term_w} + {s2_p_q[ACC_WIDTH-1], s2_p_q};
    add_ovf_w  = 1'b0;
    acc_d      = sum_w[ACC_WIDTH-1:0];
    if (sum_w > SumMax) begin
      acc_d     = AccMax;
      add_ovf_w = 1'b1;
    end else if (sum_w < SumMin) begin
      acc_d     = AccMin;
      add_ovf_w = 1'b1;
    end
    sticky_d = (first_q ? 1'b0 : sticky_q) | s2_ovf_q | add_ovf_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_p_q     <= '0;
      acc_q      <= '0;
      first_q    <= 1'b1;
      sticky_q   <= 1'b0;
      s3_valid_q <= 1'b0;
    end else if (enable) begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid & in_last;
      s1_ovf_q   <= s1_ovf_d;
      s1_zero_q  <= s1_zero_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_man_q   <= s1_man_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_ovf_q   <= big_w;
      s2_p_q     <= p_w;
      s3_valid_q <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        acc_q    <= acc_d;
        sticky_q <= sticky_d;
        first_q  <= s2_last_q;
      end
    end
  end

  // S4: conversion back to bfloat19
  fix2bf19_conv #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_conv (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (enable),
    .valid_i  (s3_valid_q),
    .acc_i    (acc_q),
    .ovf_i    (sticky_q),
    .valid_o  (out_valid),
    .num_o    (num_salida),
    .ovf_o    (ovf)
  );

endmodule

// File: tb/tb_neuron_mac_bfloat19.sv
// Directed self-checking bench for neuron_mac_bfloat19 with hand-computed bfloat19 results.
module tb_neuron_mac_bfloat19;

  localparam logic [18:0] BfOne   = 19'h1FC00;
  localparam logic [18:0] BfTwo   = 19'h20000;
  localparam logic [18:0] BfHalf  = 19'h1F800;
  localparam logic [18:0] BfNeg1  = 19'h5FC00;
  localparam logic [18:0] BfThree = 19'h20200;
  localparam logic [18:0] BfBig   = 19'h24C00;
`ifdef MAC_ROUND_NEAREST_EN
  localparam logic [18:0] SatExp  = 19'h23800;
`else
  localparam logic [18:0] SatExp  = 19'h237FF;
`endif

  logic        clk, reset, enable, in_valid, in_last;
  logic [18:0] num_x, num_w, num_salida;
  logic        out_valid, ovf;

  int n_vec = 0;
  int n_err = 0;

  neuron_mac_bfloat19 dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .num_x      (num_x),
    .num_w      (num_w),
    .out_valid  (out_valid),
    .num_salida (num_salida),
    .ovf        (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [18:0] x, input logic [18:0] w, input logic v, input logic l);
    num_x    = x;
    num_w    = w;
    in_valid = v;
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 12) begin
      idle();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_vec++;
    if (num_salida !== 19'h00000) begin
      n_err++; $display("FAIL reset_num_salida: got %h want 00000", num_salida);
    end
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %b want 0", ovf);
    end
    reset  = 1'b0;
    enable = 1'b1;
    idle();
  endtask

  task automatic test_single();
    int lat;
    drive(BfTwo, BfHalf, 1'b1, 1'b1);
    wait_result(lat);
    n_vec++;
    if (lat != 4) begin
      n_err++; $display("FAIL single_latency: got %0d want 4", lat);
    end
    n_vec++;
    if (num_salida !== 19'h1FC00) begin
      n_err++; $display("FAIL single_value: got %h want 1fc00", num_salida);
    end
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL single_ovf: got %b want 0", ovf);
    end
    idle();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_pulse: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_vector3();
    int lat;
    int early = 0;
    drive(BfOne, BfOne, 1'b1, 1'b0);
    drive(19'h0, 19'h0, 1'b0, 1'b1);  // in_last without in_valid must be ignored
    drive(BfTwo, BfOne, 1'b1, 1'b0);
    drive(BfNeg1, BfOne, 1'b1, 1'b1);
    if (out_valid === 1'b1) early++;
    wait_result(lat);
    n_vec++;
    if (lat != 4 || early != 0) begin
      n_err++; $display("FAIL vec3_latency: got %0d early %0d want 4 early 0", lat, early);
    end
    n_vec++;
    if (num_salida !== 19'h20000) begin
      n_err++; $display("FAIL vec3_value: got %h want 20000", num_salida);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(BfOne, BfThree, 1'b1, 1'b1);
    drive(BfHalf, BfOne, 1'b1, 1'b1);
    idle();
    idle();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_early: out_valid got %b want 0", out_valid);
    end
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || num_salida !== 19'h20200) begin
      n_err++; $display("FAIL b2b_first: got v=%b %h want v=1 20200", out_valid, num_salida);
    end
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || num_salida !== 19'h1F800) begin
      n_err++; $display("FAIL b2b_second: got v=%b %h want v=1 1f800", out_valid, num_salida);
    end
    idle();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_end: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_cancel();
    int lat;
    drive(BfOne, BfOne, 1'b1, 1'b0);
    drive(BfNeg1, BfOne, 1'b1, 1'b1);
    wait_result(lat);
    n_vec++;
    if (lat != 4 || num_salida !== 19'h00000 || ovf !== 1'b0) begin
      n_err++; $display("FAIL cancel: got lat=%0d %h ovf=%b want lat=4 00000 ovf=0",
                        lat, num_salida, ovf);
    end
    idle();
  endtask

  task automatic test_negative();
    int lat;
    drive(BfNeg1, BfThree, 1'b1, 1'b0);
    drive(BfHalf, BfOne, 1'b1, 1'b1);
    wait_result(lat);
    n_vec++;
    if (num_salida !== 19'h60100) begin
      n_err++; $display("FAIL negative: got %h want 60100", num_salida);
    end
    drive(19'h1FC01, 19'h1FC01, 1'b1, 1'b1);
    wait_result(lat);
    n_vec++;
    if (num_salida !== 19'h1FC02) begin
      n_err++; $display("FAIL fraction: got %h want 1fc02", num_salida);
    end
    idle();
  endtask

  task automatic test_saturation();
    int lat;
    drive(BfBig, BfOne, 1'b1, 1'b1);
    wait_result(lat);
    n_vec++;
    if (num_salida !== SatExp || ovf !== 1'b1) begin
      n_err++; $display("FAIL saturate: got %h ovf=%b want %h ovf=1", num_salida, ovf, SatExp);
    end
    idle();
    drive(BfOne, BfOne, 1'b1, 1'b1);
    wait_result(lat);
    n_vec++;
    if (num_salida !== 19'h1FC00 || ovf !== 1'b0) begin
      n_err++; $display("FAIL sticky_clear: got %h ovf=%b want 1fc00 ovf=0", num_salida, ovf);
    end
    idle();
  endtask

  task automatic test_enable_stall();
    int lat;
    drive(BfOne, BfOne, 1'b1, 1'b0);
    enable = 1'b0;
    repeat (3) drive(BfTwo, BfTwo, 1'b1, 1'b0);
    enable = 1'b1;
    drive(BfTwo, BfOne, 1'b1, 1'b1);
    enable = 1'b0;
    repeat (3) idle();
    enable = 1'b1;
    wait_result(lat);
    n_vec++;
    if (lat + 3 != 7) begin
      n_err++; $display("FAIL stall_latency: got %0d want 7", lat + 3);
    end
    n_vec++;
    if (num_salida !== 19'h20200) begin
      n_err++; $display("FAIL stall_value: got %h want 20200", num_salida);
    end
    enable = 1'b0;
    idle();
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || num_salida !== 19'h20200) begin
      n_err++; $display("FAIL stall_hold: got v=%b %h want v=1 20200", out_valid, num_salida);
    end
    enable = 1'b1;
    idle();
    n_vec++;
    if (out_valid !== 1'b0 || num_salida !== 19'h20200) begin
      n_err++; $display("FAIL stall_release: got v=%b %h want v=0 20200", out_valid, num_salida);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses = 0;
    drive(BfOne, BfOne, 1'b1, 1'b0);
    drive(BfOne, BfOne, 1'b1, 1'b1);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    n_vec++;
    if (num_salida !== 19'h00000) begin
      n_err++; $display("FAIL midreset_clear: got %h want 00000", num_salida);
    end
    for (int i = 0; i < 8; i++) begin
      idle();
      if (out_valid === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++; $display("FAIL midreset_no_output: got %0d pulses want 0", pulses);
    end
    drive(BfOne, BfOne, 1'b1, 1'b1);
    wait_result(lat);
    n_vec++;
    if (lat != 4 || num_salida !== 19'h1FC00) begin
      n_err++; $display("FAIL midreset_next: got lat=%0d %h want lat=4 1fc00", lat, num_salida);
    end
    idle();
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    num_x    = '0;
    num_w    = '0;
    test_reset();
    test_single();
    test_vector3();
    test_back_to_back();
    test_cancel();
    test_negative();
    test_saturation();
    test_enable_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
